// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit. Sub-word (byte/half) support is
// compiled in only when LSU_SUBWORD_EN is defined.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int RAM_AW = 12;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    RESP
  } state_e;

  // Illegal size or misaligned lane; such requests never touch the RAM.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    case (size)
`ifdef LSU_SUBWORD_EN
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
`endif
      SZ_W:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: load extract/extend and sub-word store merge
// into the word read back from RAM. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              zext,
  input  logic [DATA_W-1:0] rdata,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] st_word
);

  logic        [7:0]  b_sel;
  logic        [15:0] h_sel;
  logic signed [7:0]  b_s;
  logic signed [15:0] h_s;

  always_comb begin
    case (lane)
      2'd0:    b_sel = rdata[7:0];
      2'd1:    b_sel = rdata[15:8];
      2'd2:    b_sel = rdata[23:16];
      default: b_sel = rdata[31:24];
    endcase
    h_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    b_s   = signed'(b_sel);
    h_s   = signed'(h_sel);

    case (size)
      SZ_B:    ld_data = zext ? {24'b0, b_sel} : DATA_W'(b_s);
      SZ_H:    ld_data = zext ? {16'b0, h_sel} : DATA_W'(h_s);
      default: ld_data = rdata;
    endcase
  end

  // Only the addressed lane(s) take the low bits of the store data.
  always_comb begin
    st_word = rdata;
    case (size)
      SZ_B: begin
        case (lane)
          2'd0:    st_word[7:0]   = wdata[7:0];
          2'd1:    st_word[15:8]  = wdata[7:0];
          2'd2:    st_word[23:16] = wdata[7:0];
          default: st_word[31:24] = wdata[7:0];
        endcase
      end
      SZ_H: begin
        if (lane[1]) st_word[31:16] = wdata[15:0];
        else         st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit between a CPU request port and a registered-read word RAM.
// Define LSU_SUBWORD_EN to enable byte/half accesses (read-modify-write stores).
module lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [13:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_sel,
  output logic              mem_ld,
  output logic              mem_str,
  output logic              mem_clr,
  output logic [RAM_AW-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  logic              sel_q, ld_q, str_q;
  logic [1:0]        lane_p0;
  logic [1:0]        size_p0;
  logic              we_p0;
  logic              zext_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  assign mem_clr = ~clr_n;
  // Gating by clr_n stops a strobe already registered from reaching the RAM on the reset edge.
  assign mem_sel = sel_q & clr_n;
  assign mem_ld  = ld_q  & clr_n;
  assign mem_str = str_q & clr_n;

  // Stage p0: request captured at acceptance; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      lane_p0  <= req_addr[1:0];
      size_p0  <= req_size;
      we_p0    <= req_we;
      zext_p0  <= req_unsigned;
      wdata_p0 <= req_wdata;
    end
  end

  lsu_align u_align (
    .size    (size_p0),
    .lane    (lane_p0),
    .zext    (zext_p0),
    .rdata   (mem_rdata),
    .wdata   (wdata_p0),
    .ld_data (ld_data),
    .st_word (st_word)
  );

`ifndef LSU_SUBWORD_EN
  logic unused_ok;
  assign unused_ok = ^{we_p0, st_word};
`endif

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      sel_q       <= 1'b0;
      ld_q        <= 1'b0;
      str_q       <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      sel_q     <= 1'b0;
      ld_q      <= 1'b0;
      str_q     <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid) begin
            req_ready   <= 1'b0;
            mem_address <= req_addr[13:2];
            if (access_err(req_size, req_addr[1:0])) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (req_we && req_size == SZ_W) begin
              state     <= WR_ISSUE;
              sel_q     <= 1'b1;
              str_q     <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              // Loads and sub-word stores both start by reading the word.
              state <= RD_ISSUE;
              sel_q <= 1'b1;
              ld_q  <= 1'b1;
            end
          end
        end
        RD_ISSUE: state <= RD_WAIT;
        RD_WAIT: begin
`ifdef LSU_SUBWORD_EN
          if (we_p0) begin
            state     <= WR_ISSUE;
            sel_q     <= 1'b1;
            str_q     <= 1'b1;
            mem_wdata <= st_word;
          end else
`endif
          begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_data;
          end
        end
        WR_ISSUE: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed scenarios plus randomized accesses
// checked against a byte-lane arithmetic model of memory and responses.
module tb_lsu;

`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_sel, mem_ld, mem_str, mem_clr;
  logic [11:0] mem_address;
  logic [31:0] mem_wdata, mem_rdata;

  lsu dut (
    .clk(clk), .clr_n(clr_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_sel(mem_sel), .mem_ld(mem_ld), .mem_str(mem_str),
    .mem_clr(mem_clr), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Word RAM with registered read data.
  logic [31:0] ram [4096];
  bit          do_init = 1'b1;
  always @(posedge clk) begin
    if (do_init) begin
      for (int i = 0; i < 4096; i++) ram[i] <= seed_word(i);
    end else begin
      if (mem_sel && mem_str) ram[mem_address] <= mem_wdata;
      if (mem_sel && mem_ld)  mem_rdata <= ram[mem_address];
    end
  end

  // Strobe activity, cumulative; the main sequence works on differences.
  int ld_cnt = 0, st_cnt = 0, sel_cnt = 0, rsp_cnt = 0, proto_bad = 0;
  always @(negedge clk) begin
    if (mem_sel && mem_ld)  ld_cnt++;
    if (mem_sel && mem_str) st_cnt++;
    if (mem_sel)            sel_cnt++;
    if (rsp_valid)          rsp_cnt++;
    if ((mem_ld && mem_str) || ((mem_ld || mem_str) && !mem_sel) ||
        (mem_sel && (req_ready || rsp_valid)))
      proto_bad++;
  end

  int nvec = 0, nerr = 0;
  bit [31:0] ref_mem [4096];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input bit [1:0] size, input bit [13:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size != 2'd2 && !SUBWORD) return 1'b1;
    if (size == 2'd1) return addr[0];
    if (size == 2'd2) return addr[1:0] != 2'd0;
    return 1'b0;
  endfunction

  function automatic bit [31:0] size_mask(input bit [1:0] size);
    return (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic do_op(input bit we, input bit [1:0] size, input bit uns,
                       input bit [13:0] addr, input bit [31:0] wdata, input string tag);
    bit        err;
    int        lat, sh, cyc, ld0, st0, sel0, exp_ld, exp_st;
    bit [31:0] w, v, mask, exp_rd;
    err    = model_err(size, addr);
    sh     = 8 * int'(addr % 4);
    w      = ref_mem[addr / 4];
    mask   = size_mask(size);
    exp_rd = 32'h0;
    exp_ld = 0;
    exp_st = 0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat    = 3;
      exp_ld = 1;
      v      = (w >> sh) & mask;
      if (!uns && size == 2'd0 && v >= 32'd128)   v = v - 32'd256;
      if (!uns && size == 2'd1 && v >= 32'd32768) v = v - 32'd65536;
      exp_rd = v;
    end else begin
      lat    = (size == 2'd2) ? 2 : 4;
      exp_ld = (size == 2'd2) ? 0 : 1;
      exp_st = 1;
      ref_mem[addr / 4] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
    end

    chk({tag, ".ready"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr;  req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = 14'($urandom); req_wdata = $urandom;
    ld0 = ld_cnt; st0 = st_cnt; sel0 = sel_cnt;
    chk({tag, ".busy"}, req_ready, 0);
    cyc = 1;
    while (!rsp_valid && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".lat"},   32'(cyc), 32'(lat));
    chk({tag, ".err"},   rsp_err, err);
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".nld"},   32'(ld_cnt - ld0), 32'(exp_ld));
    chk({tag, ".nstr"},  32'(st_cnt - st0), 32'(exp_st));
    if (err) chk({tag, ".nsel"}, 32'(sel_cnt - sel0), 0);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, rsp_valid, 0);
    chk({tag, ".idle"},  req_ready, 1);
    if (we) chk({tag, ".word"}, ram[addr / 4], ref_mem[addr / 4]);
  endtask

  initial begin
    int st0, rsp0;
    clr_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", req_ready, 1);
    chk("rst.rsp",   {rsp_valid, rsp_err}, 0);
    chk("rst.rdata", rsp_rdata, 0);
    chk("rst.strb",  {mem_sel, mem_ld, mem_str}, 0);
    chk("rst.clr",   mem_clr, 1);
    chk("rst.addr",  mem_address, 0);
    chk("rst.wdata", mem_wdata, 0);
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_word(i);
    @(negedge clk);
    clr_n = 1'b1; do_init = 1'b0;
    @(posedge clk); #1;
    chk("run.clr", mem_clr, 0);

    // Word 10 = 0x12341234, then the sub-word loads and stores around it.
    do_op(1, 2'd2, 0, 14'h028, 32'h1234_1234, "sw10");
    do_op(0, 2'd0, 0, 14'h028, 32'h0, "lb28");
    do_op(0, 2'd1, 0, 14'h02A, 32'h0, "lh2a");
    do_op(0, 2'd2, 0, 14'h02A, 32'h0, "lw2a");
    do_op(1, 2'd0, 0, 14'h029, 32'hFFFF_FFAB, "sb29");
    do_op(0, 2'd2, 0, 14'h028, 32'h0, "lw28");
    do_op(1, 2'd0, 0, 14'h028, 32'h0000_0080, "sb28");
    do_op(0, 2'd0, 0, 14'h028, 32'h0, "lb28s");
    do_op(0, 2'd0, 1, 14'h028, 32'h0, "lbu28");
    do_op(0, 2'd3, 0, 14'h028, 32'h0, "ill");
    do_op(1, 2'd1, 0, 14'h02B, 32'h1111, "shmis");

    // Reset while a half store sits in its read phase: nothing may be written.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 14'h028; req_wdata = 32'h0000_5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    st0 = st_cnt; rsp0 = rsp_cnt;
    @(negedge clk);
    clr_n = 1'b0;
    @(posedge clk); #1;
    chk("abort.ready", req_ready, 1);
    chk("abort.clr",   mem_clr, 1);
    chk("abort.rsp",   rsp_valid, 0);
    @(negedge clk);
    clr_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.nstr",  32'(st_cnt - st0), 0);
    chk("abort.nrsp",  32'(rsp_cnt - rsp0), 0);
    chk("abort.word",  ram[10], ref_mem[10]);
    chk("abort.ready2", req_ready, 1);

    for (int n = 0; n < 120; n++) begin
      do_op(1'($urandom), 2'($urandom), 1'($urandom), 14'($urandom_range(0, 63)),
            $urandom, "rnd");
    end
    for (int i = 0; i < 16; i++) chk("final.word", ram[i], ref_mem[i]);
    chk("protocol", 32'(proto_bad), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-002 SHALL have port clr_n, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: CPU access request.
REQ-004 SHALL have port req_ready, output, 1 bit: request accepted on a clk edge where req_valid && req_ready.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have port req_unsigned, input, 1 bit: zero-extend load data when set; sign-extend otherwise.
REQ-008 SHALL have port req_addr, input, 14 bits: byte address; [13:2] is the word, [1:0] is the lane.
REQ-009 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-010 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse with no backpressure.
REQ-011 SHALL have port rsp_rdata, output, 32 bits: extended load data, valid with rsp_valid; 0 for stores.
REQ-012 SHALL have port rsp_err, output, 1 bit: misaligned or illegal size, valid with rsp_valid.
REQ-013 SHALL have ports mem_sel, mem_ld and mem_str, outputs, 1 bit each: word-RAM strobes.
REQ-014 SHALL have port mem_clr, output, 1 bit: RAM clear, driven as ~clr_n.
REQ-015 SHALL have port mem_address, output, 12 bits: RAM word address.
REQ-016 SHALL have port mem_wdata, output, 32 bits: RAM write data.
REQ-017 SHALL have port mem_rdata, input, 32 bits: RAM read data, registered by the RAM and valid the cycle after the sel&ld cycle.

Function
REQ-018 SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP, with req_ready=1 only in IDLE.
REQ-019 SHALL flag an error when size=11, half with addr[0]=1, or word with addr[1:0]!=0; on error it SHALL go IDLE->RESP, raise rsp_err=1 and make no memory access.
REQ-020 SHALL sequence a load as IDLE->RD_ISSUE (sel=ld=1)->RD_WAIT (capture mem_rdata)->RESP, giving rsp_valid 3 cycles after acceptance.
REQ-021 SHALL sequence a word store as IDLE->WR_ISSUE (sel=str=1, mem_wdata=req_wdata)->RESP, giving rsp_valid 2 cycles after acceptance.
REQ-022 SHALL sequence a byte/half store as read-modify-write: RD_ISSUE->RD_WAIT->WR_ISSUE (merged word)->RESP, giving rsp_valid 4 cycles after acceptance.
REQ-023 SHALL use little-endian lanes: lane n = bits [8n+7:8n], half at addr[1]=1 = bits [31:16].
REQ-024 SHALL merge sub-word stores by replacing only the addressed lane(s) with the low bits of req_wdata.
REQ-025 SHALL register the request (addr, size, we, unsigned, wdata) at acceptance; later input changes SHALL have no effect.
REQ-026 SHALL assert at most one of mem_ld/mem_str per cycle, never outside sel, and never in IDLE or RESP.
REQ-027 SHALL return RESP->IDLE unconditionally, so a new request can be accepted the cycle after rsp_valid.

Reset
REQ-028 SHALL, with clr_n=0 at an edge, enter IDLE and clear all outputs to 0 (req_ready=1, mem_clr=1).
REQ-029 SHALL abort any in-flight access on reset mid-operation: no mem_str from the reset cycle on and no rsp_valid for the aborted request.

Configuration
REQ-030 SHALL, with LSU_SUBWORD_EN defined, support byte/half accesses as specified above.
REQ-031 SHALL, without LSU_SUBWORD_EN, treat size 00/01 as illegal (rsp_err=1, no access) and omit the read-modify-write path.

Structure
REQ-032 SHALL place the size encodings SZ_B/SZ_H/SZ_W, the state enum and RAM_AW=12 in package lsu_pkg.
REQ-033 SHALL use one combinational sub-module, lsu_align, for lane extract/extend and store merge.

Verification
REQ-034 SHALL check: RAM word 10 = 0x12341234; LB signed at addr 0x028 -> rsp_rdata=0x00000034, rsp_valid on cycle 3.
REQ-035 SHALL check: LH signed at 0x02A -> 0x00001234; LW at 0x02A -> rsp_err=1, mem_sel never high.
REQ-036 SHALL check: SB 0xAB at 0x029 -> one ld then one str, word 10 becomes 0x1234AB34, rsp_valid on cycle 4.
REQ-037 SHALL check: SB 0x80 at 0x028, then LB -> 0xFFFFFF80 and LBU -> 0x00000080.
REQ-038 SHALL check: clr_n=0 during RD_WAIT of an SH -> no mem_str, word unchanged, req_ready=1 after the reset cycle.
REQ-039 SHALL check: with LSU_SUBWORD_EN undefined, LB at 0x028 -> rsp_err=1 and SW still writes in 2 cycles.
